// File: rtl/temporal_result_decoder.sv
// Unary-to-binary result decoder: counts per-lane high cycles over a framed window and emits signed values on valid/ready.
// Optional early window termination on an all-zero sample cycle: define TEMPORAL_DECODER_EARLY_TERM_EN.
module temporal_result_decoder #(
  parameter int LANES      = 16,
  parameter int BIT_WIDTH  = 4,
  parameter int WINDOW_LEN = 1 << (BIT_WIDTH - 2),
  parameter int CNT_W      = $clog2(WINDOW_LEN + 1),
  parameter int OUT_W      = BIT_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_start,
  input  logic [LANES-1:0]       lane_unary,
  input  logic [LANES-1:0]       lane_neg,
  input  logic [LANES-1:0]       lane_odd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic                   busy,
  output logic                   overrun
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic             overrun_q, overrun_d;
  logic             start;
  logic             sample;
  logic             close;
  logic             zero_cycle;

`ifdef TEMPORAL_DECODER_EARLY_TERM_EN
  // An all-zero sample cycle mirrors the encoder's counter clear and ends the window.
  assign zero_cycle = ~|lane_unary;
`else
  assign zero_cycle = 1'b0;
`endif

  // start: load a fresh window this cycle; sample: accumulate into the running window.
  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    overrun_d = 1'b0;
    start     = 1'b0;
    sample    = 1'b0;
    close     = 1'b0;
    case (state_q)
      IDLE: begin
        start = frame_start;
      end
      COLLECT: begin
        start  = frame_start;
        sample = !frame_start;
      end
      HOLD: begin
        if (frame_start && !out_ready) begin
          overrun_d = 1'b1;
        end else if (out_ready) begin
          start = frame_start;
          if (!frame_start) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      win_d   = CNT_W'(1);
      state_d = COLLECT;
    end else if (sample) begin
      win_d = win_q + CNT_W'(1);
    end

    if ((start || sample) && ((win_d == CNT_W'(WINDOW_LEN)) || zero_cycle)) begin
      close   = 1'b1;
      state_d = HOLD;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      win_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      overrun_q <= overrun_d;
    end
  end

  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == COLLECT);
  assign overrun   = overrun_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             odd_q, odd_d;
    logic [OUT_W-1:0] mag;
    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] data_q;

    assign neg_d = start ? lane_neg[gi] : neg_q;
    assign odd_d = start ? lane_odd[gi] : odd_q;

    // Saturate at the window length so stray highs cannot wrap the count.
    always_comb begin
      cnt_d = cnt_q;
      if (start) begin
        cnt_d = CNT_W'(lane_unary[gi]);
      end else if (sample && lane_unary[gi] && (cnt_q != CNT_W'(WINDOW_LEN))) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Decode from the next-state count so the result lands together with HOLD entry.
    assign mag = (OUT_W'(cnt_d) << 1) - OUT_W'(odd_d);
    assign dec = (cnt_d == '0) ? '0 : (neg_d ? -mag : mag);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q  <= '0;
        neg_q  <= 1'b0;
        odd_q  <= 1'b0;
        data_q <= '0;
      end else begin
        cnt_q <= cnt_d;
        neg_q <= neg_d;
        odd_q <= odd_d;
        if (close) begin
          data_q <= dec;
        end
      end
    end

    assign out_data[gi*OUT_W +: OUT_W] = data_q;
  end

endmodule

// File: tb/tb_temporal_result_decoder.sv
// Self-checking bench for temporal_result_decoder (2 lanes, 4-bit operands): vector table, corner sequences, random frames.
module tb_temporal_result_decoder;

  localparam int WL = 4;

  logic       clk;
  logic       reset_n;
  logic       frame_start;
  logic [1:0] lane_unary;
  logic [1:0] lane_neg;
  logic [1:0] lane_odd;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic       busy;
  logic       overrun;

  int tests = 0;
  int fails = 0;

  temporal_result_decoder #(
    .LANES(2),
    .BIT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_start(frame_start),
    .lane_unary(lane_unary),
    .lane_neg(lane_neg),
    .lane_odd(lane_odd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .busy(busy),
    .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] neg;
    logic [1:0] odd;
    logic [7:0] pat;     // {cycle3, cycle2, cycle1, cycle0}, bit0 of each pair = lane0
    logic [9:0] exp;     // {lane1, lane0}
    int         lat_et;  // latency when the all-zero early end is enabled
  } vec_t;

  vec_t tbl [6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: count highs per lane up to the window end, then sign/odd arithmetic on integers.
  function automatic void model(input logic [1:0] neg, input logic [1:0] odd, input logic [7:0] pat,
                                output logic [9:0] data, output int lat);
    int last;
    int cnt;
    int m;
    int v;
    last = WL - 1;
`ifdef TEMPORAL_DECODER_EARLY_TERM_EN
    for (int k = WL - 1; k >= 0; k--) begin
      if (pat[2*k +: 2] == 2'b00) last = k;
    end
`endif
    lat  = last + 1;
    data = '0;
    for (int i = 0; i < 2; i++) begin
      cnt = 0;
      for (int k = 0; k <= last; k++) cnt += int'(pat[2*k + i]);
      m = 2 * cnt - int'(odd[i]);
      v = neg[i] ? -m : m;
      if (cnt == 0) v = 0;
      data[i*5 +: 5] = v[4:0];
    end
  endfunction

  task automatic run_frame(input logic [1:0] neg, input logic [1:0] odd, input logic [7:0] pat,
                           input logic rdy0, input logic [9:0] exp, input int lat, input string name);
    int  k;
    bit  seen;
    int  got;
    seen = 1'b0;
    got  = -1;
    k    = 0;
    while (!seen && k < 3 * WL) begin
      frame_start = (k == 0);
      out_ready   = (k == 0) ? rdy0 : 1'b0;
      lane_neg    = (k == 0) ? neg : 2'($urandom);
      lane_odd    = (k == 0) ? odd : 2'($urandom);
      lane_unary  = (k < WL) ? pat[2*k +: 2] : 2'($urandom);
      tick();
      if (k == 0) check({name, " no overrun"}, 32'(overrun), 32'd0);
      if (out_valid) begin
        seen = 1'b1;
        got  = k + 1;
      end
      k++;
    end
    frame_start = 1'b0;
    out_ready   = 1'b0;
    lane_unary  = '0;
    check({name, " latency"}, 32'(got), 32'(lat));
    check({name, " data"}, 32'(out_data), 32'(exp));
    $display("[TB] frame %s neg=%b odd=%b pat=%b lat=%0d data=%b", name, neg, odd, pat, got, out_data);
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " valid drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [9:0] held;
    logic [9:0] mexp;
    int         mlat;
    int         elat;
    logic [1:0] rn;
    logic [1:0] ro;
    logic [7:0] rp;

    tbl[0] = '{neg: 2'b10, odd: 2'b01, pat: 8'b00_11_11_11, exp: {5'b11010, 5'b00101}, lat_et: 4};
    tbl[1] = '{neg: 2'b10, odd: 2'b01, pat: 8'b10_10_11_11, exp: {5'b11000, 5'b00011}, lat_et: 4};
    tbl[2] = '{neg: 2'b11, odd: 2'b11, pat: 8'b00_00_00_00, exp: 10'd0,                 lat_et: 1};
    tbl[3] = '{neg: 2'b01, odd: 2'b01, pat: 8'b00_00_10_11, exp: {5'b00100, 5'b11111}, lat_et: 3};
    tbl[4] = '{neg: 2'b00, odd: 2'b11, pat: 8'b01_01_01_11, exp: {5'b00001, 5'b00111}, lat_et: 4};
    tbl[5] = '{neg: 2'b00, odd: 2'b00, pat: 8'b00_00_00_11, exp: {5'b00010, 5'b00010}, lat_et: 2};

    reset_n     = 1'b0;
    frame_start = 1'b0;
    lane_unary  = '0;
    lane_neg    = '0;
    lane_odd    = '0;
    out_ready   = 1'b0;
    #1;
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);
    check("reset data", 32'(out_data), 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
`ifdef TEMPORAL_DECODER_EARLY_TERM_EN
      elat = tbl[i].lat_et;
`else
      elat = WL;
`endif
      run_frame(tbl[i].neg, tbl[i].odd, tbl[i].pat, 1'b0, tbl[i].exp, elat, $sformatf("tbl%0d", i));
      accept($sformatf("tbl%0d", i));
    end

    // Backpressure: data must hold for 5 stalled cycles while late highs are ignored.
    run_frame(tbl[0].neg, tbl[0].odd, tbl[0].pat, 1'b0, tbl[0].exp, WL, "hold");
    for (int c = 0; c < 5; c++) begin
      lane_unary = 2'($urandom);
      tick();
      check("hold valid", 32'(out_valid), 32'd1);
      check("hold data", 32'(out_data), 32'(tbl[0].exp));
    end
    lane_unary = '0;
    accept("hold");

    // Dropped frame in HOLD, then back-to-back accept-and-start.
    run_frame(tbl[1].neg, tbl[1].odd, tbl[1].pat, 1'b0, tbl[1].exp, WL, "ovr");
    held        = out_data;
    frame_start = 1'b1;
    lane_unary  = 2'b11;
    lane_neg    = 2'b11;
    lane_odd    = 2'b11;
    tick();
    frame_start = 1'b0;
    check("ovr pulse", 32'(overrun), 32'd1);
    check("ovr valid kept", 32'(out_valid), 32'd1);
    check("ovr busy", 32'(busy), 32'd0);
    check("ovr data kept", 32'(out_data), 32'(held));
    tick();
    check("ovr pulse end", 32'(overrun), 32'd0);
    check("ovr data kept2", 32'(out_data), 32'(held));
    $display("[TB] overrun pulse seen, data=%b", out_data);
    run_frame(tbl[4].neg, tbl[4].odd, tbl[4].pat, 1'b1, tbl[4].exp, WL, "nogap");
    accept("nogap");

    // Restart two cycles into COLLECT: only the second frame counts.
    frame_start = 1'b1;
    lane_unary  = 2'b11;
    lane_neg    = 2'b00;
    lane_odd    = 2'b00;
    tick();
    frame_start = 1'b0;
    check("abort busy", 32'(busy), 32'd1);
    tick();
`ifdef TEMPORAL_DECODER_EARLY_TERM_EN
    elat = 3;
`else
    elat = WL;
`endif
    run_frame(2'b11, 2'b01, 8'b00_00_01_01, 1'b0, {5'b00000, 5'b11101}, elat, "abort");
    accept("abort");

    // Asynchronous reset mid-COLLECT clears everything at once.
    frame_start = 1'b1;
    lane_unary  = 2'b11;
    tick();
    frame_start = 1'b0;
    check("pre-reset busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async rst busy", 32'(busy), 32'd0);
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst data", 32'(out_data), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset valid", 32'(out_valid), 32'd0);
    $display("[TB] reset mid-frame handled");

    // Random frames against the reference model; DUT sits in HOLD between iterations.
    model(tbl[0].neg, tbl[0].odd, tbl[0].pat, mexp, mlat);
    run_frame(tbl[0].neg, tbl[0].odd, tbl[0].pat, 1'b0, mexp, mlat, "rand_init");
    for (int r = 0; r < 40; r++) begin
      rn = 2'($urandom);
      ro = 2'($urandom);
      rp = 8'($urandom);
      model(rn, ro, rp, mexp, mlat);
      if ($urandom_range(1, 0) == 1) begin
        run_frame(rn, ro, rp, 1'b1, mexp, mlat, $sformatf("rand%0d_b2b", r));
      end else begin
        accept($sformatf("rand%0d", r));
        run_frame(rn, ro, rp, 1'b0, mexp, mlat, $sformatf("rand%0d", r));
      end
    end
    accept("rand_end");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
